// File: rtl/rej_bounded_poly.sv
// Rejection sampler for one ML-DSA secret polynomial (RejBoundedPoly).
// Consumes SHAKE256 squeeze words over a valid/ready handshake. It scans one byte per cycle,
// low nibble first. Each accepted nibble becomes a coefficient in [-ETA, ETA], stored as
// COEFF_WIDTH-bit two's complement.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    pulse; begins sampling from IDLE or DONE, ignored otherwise
//   in_data  squeeze word, byte 0 = in_data[7:0] first in stream order
//   in_valid in_data valid
//   in_ready sampler accepts a word this cycle (WAIT_WORD only)
//   poly     coefficient i at poly[COEFF_WIDTH*i +: COEFF_WIDTH]
//   busy     high while waiting for or scanning a word
//   done     level, high once all N coefficients are written
module rej_bounded_poly #(
    parameter int unsigned N            = 256,
    parameter int unsigned ETA          = 2,   // only 2 and 4 are meaningful
    parameter int unsigned COEFF_WIDTH  = 4,   // must be >= 4
    parameter int unsigned DATA_IN_BITS = 64   // multiple of 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_IN_BITS-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [COEFF_WIDTH*N-1:0]  poly,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned NumBytes = DATA_IN_BITS / 8;
    localparam int unsigned ByteIdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned CtrW     = $clog2(N + 1);

    localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(NumBytes - 1);
    localparam logic [CtrW-1:0]     CtrFull  = CtrW'(N);
    localparam logic [CtrW-1:0]     CtrOne   = CtrW'(1);

    typedef enum logic [1:0] {StIdle, StWaitWord, StScan, StDone} state_e;

    state_e                     state_q, state_d;
    logic [DATA_IN_BITS-1:0]    word_q, word_d;
    logic [ByteIdxW-1:0]        byte_q, byte_d;
    logic [CtrW-1:0]            ctr_q, ctr_d;
    logic [COEFF_WIDTH*N-1:0]   poly_q, poly_d;

    logic [7:0]                 cur_byte;
    logic [3:0]                 z0, z1;
    logic [CtrW-1:0]            ctr_v;

    function automatic logic nib_ok(input logic [3:0] z);
        if (ETA == 2) return z < 4'd15;
        else          return z < 4'd9;
    endfunction

    // Coefficient is computed in 4 bits then sign-extended to COEFF_WIDTH.
    function automatic logic [COEFF_WIDTH-1:0] nib_coeff(input logic [3:0] z);
        logic signed [3:0] v;
        if (ETA == 2) v = signed'(4'd2 - (z % 4'd5));
        else          v = signed'(4'd4 - z);
        return COEFF_WIDTH'(v);
    endfunction

    assign cur_byte = word_q[8*int'(byte_q) +: 8];
    assign z0       = cur_byte[3:0];
    assign z1       = cur_byte[7:4];
    assign poly     = poly_q;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        byte_d   = byte_q;
        ctr_d    = ctr_q;
        poly_d   = poly_q;
        ctr_v    = ctr_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                // poly is left as is: every entry is rewritten before done.
                if (start) begin
                    ctr_d   = '0;
                    byte_d  = '0;
                    state_d = StWaitWord;
                end
            end
            StWaitWord: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    byte_d  = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                busy = 1'b1;
                if (ctr_q == CtrFull) begin
                    // Filled on the previous byte; the rest of the word is dropped.
                    state_d = StDone;
                end else begin
                    if (nib_ok(z0)) begin
                        poly_d[COEFF_WIDTH*int'(ctr_v) +: COEFF_WIDTH] = nib_coeff(z0);
                        ctr_v = ctr_v + CtrOne;
                    end
                    // z1 is discarded when z0 just filled the last entry.
                    if (nib_ok(z1) && (ctr_v != CtrFull)) begin
                        poly_d[COEFF_WIDTH*int'(ctr_v) +: COEFF_WIDTH] = nib_coeff(z1);
                        ctr_v = ctr_v + CtrOne;
                    end
                    ctr_d = ctr_v;
                    if (byte_q == LastByte) begin
                        byte_d = '0;
                        if (ctr_v != CtrFull) state_d = StWaitWord;
                    end else begin
                        byte_d = byte_q + ByteIdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            byte_q  <= '0;
            ctr_q   <= '0;
            poly_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            ctr_q   <= ctr_d;
            poly_q  <= poly_d;
        end
    end

endmodule

// File: tb/tb_rej_bounded_poly.sv
// Directed bench for rej_bounded_poly: an ETA=2 instance for the main stream tests and an
// ETA=4 instance for the ETA=4 acceptance/mapping vector.
module tb_rej_bounded_poly;

    localparam int N  = 256;
    localparam int CW = 4;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst, start, start4, in_valid, valid4;
    logic [DW-1:0]   in_data, data4;
    logic            in_ready, busy, done, ready4, busy4, done4;
    logic [CW*N-1:0] poly, poly4;

    int n_checks = 0;
    int n_errors = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    rej_bounded_poly #(.N(N), .ETA(2), .COEFF_WIDTH(CW), .DATA_IN_BITS(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .poly(poly), .busy(busy), .done(done)
    );

    rej_bounded_poly #(.N(N), .ETA(4), .COEFF_WIDTH(CW), .DATA_IN_BITS(DW)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_data(data4), .in_valid(valid4),
        .in_ready(ready4), .poly(poly4), .busy(busy4), .done(done4)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cf(input logic [CW*N-1:0] p, input int i);
        return p[CW*i +: CW];
    endfunction

    function automatic int n_diff(input logic [CW*N-1:0] a, input logic [CW*N-1:0] b);
        int n = 0;
        for (int i = 0; i < N; i++) if (a[CW*i +: CW] !== b[CW*i +: CW]) n++;
        return n;
    endfunction

    // Stream sources: 0 zeros, 1 forty 0xFF words then zeros, 2 pseudo-random,
    // 3 fill-boundary pattern, 4 first word 0x..F73E then zeros.
    function automatic logic [63:0] word_at(input int mode, input int idx);
        logic [31:0] a, b;
        case (mode)
            1: return (idx < 40) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            2: begin
                a = 32'(idx + 1) * 32'h9E37_79B9;
                b = (a ^ (a >> 13)) * 32'h85EB_CA6B;
                return {b ^ 32'h1B87_3593, a ^ (b >> 7)};
            end
            3: begin
                if (idx < 15)  return 64'h3333_3333_3333_3333;
                if (idx == 15) return 64'hF333_3333_3333_3333;
                return 64'h1111_1111_1111_1100;
            end
            4: return (idx == 0) ? 64'h0000_0000_0000_F73E : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    // Reference RejBoundedPoly for ETA=2 over a stream source.
    task automatic model(input int mode, output logic [CW*N-1:0] p, output int words);
        int ctr = 0;
        logic [63:0] w;
        logic [7:0] by;
        int z;
        p = '0;
        words = 0;
        while (ctr < N) begin
            w = word_at(mode, words);
            words++;
            for (int b = 0; b < DW / 8; b++) begin
                by = w[8*b +: 8];
                for (int h = 0; h < 2; h++) begin
                    z = (h == 0) ? int'(by[3:0]) : int'(by[7:4]);
                    if (ctr < N && z < 15) begin
                        p[CW*ctr +: CW] = 4'(2 - (z % 5));
                        ctr++;
                    end
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives words until done or budget edges; cycles counts edges since the start edge.
    task automatic feed(input int mode, input int max_gap, input int budget, input int start_at,
                        output int words, output int cycles);
        int gap;
        logic acc;
        words = 0;
        cycles = 0;
        acc_q.delete();
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        while (cycles < budget && !done) begin
            in_valid = (gap == 0);
            in_data  = word_at(mode, words);
            start    = (cycles == start_at);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            cycles++;
            if (acc) begin
                words++;
                acc_q.push_back(cycles);
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            end else if (gap > 0) begin
                gap--;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW*N-1:0] all2, fillp, expp, golden, gapfree;
        int w, c, ew, bad, k;

        for (int i = 0; i < N; i++) begin
            all2[CW*i +: CW]  = 4'h2;
            fillp[CW*i +: CW] = (i == N - 1) ? 4'h2 : 4'hF;
        end

        rst = 1'b1; start = 1'b0; start4 = 1'b0; in_valid = 1'b0; valid4 = 1'b0;
        in_data = '0; data4 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_poly_nonzero", 64'(n_diff(poly, '0)), 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Golden all-zero run.
        pulse_start();
        feed(0, 0, 2000, -1, w, c);
        check_eq("zero_done_cycle", c, 145);
        check_eq("zero_words", w, 16);
        check_eq("zero_last_accept", acc_q[$], 136);
        check_eq("zero_poly", n_diff(poly, all2), 0);
        check_eq("zero_in_ready_low", in_ready, 0);
        golden = poly;

        // All-0xFF words are fully rejected; cadence is one accept every 9 cycles.
        pulse_start();
        feed(1, 0, 2000, -1, w, c);
        bad = 0;
        for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 9) bad++;
        check_eq("ff_first_accept", acc_q[0], 1);
        check_eq("ff_accept_spacing", bad, 0);
        check_eq("ff_words", w, 56);
        check_eq("ff_done_cycle", c, 505);
        check_eq("ff_poly", n_diff(poly, all2), 0);

        // Byte 0x3E -> -2,-1; byte 0xF7 -> single 0.
        pulse_start();
        feed(4, 0, 2000, -1, w, c);
        check_eq("b3e_poly0", cf(poly, 0), 4'hE);
        check_eq("b3e_poly1", cf(poly, 1), 4'hF);
        check_eq("bf7_poly2", cf(poly, 2), 4'h0);
        check_eq("bf7_poly3", cf(poly, 3), 4'h2);
        check_eq("b3e_words", w, 17);

        // ETA=4: bytes 08, 7F, 00 -> -4, 4, -3, 4, 4.
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        valid4 = 1'b1;
        data4  = 64'h0000_0000_0000_7F08;
        k = 0;
        while (!ready4 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("eta4_ready", ready4, 1);
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("eta4_poly0", cf(poly4, 0), 4'hC);
        check_eq("eta4_poly1", cf(poly4, 1), 4'h4);
        check_eq("eta4_poly2", cf(poly4, 2), 4'hD);
        check_eq("eta4_poly3", cf(poly4, 3), 4'h4);
        check_eq("eta4_poly5", cf(poly4, 5), 4'h0);
        check_eq("eta4_busy", busy4, 1);

        // Fill boundary: 255 coefficients of -1, then byte 0x00 fills only entry 255.
        pulse_start();
        feed(3, 0, 2000, -1, w, c);
        check_eq("fill_words", w, 17);
        check_eq("fill_last_accept", acc_q[$], 145);
        check_eq("fill_done_cycle", c, 147);
        check_eq("fill_poly255", cf(poly, 255), 4'h2);
        check_eq("fill_poly", n_diff(poly, fillp), 0);
        in_valid = 1'b1;
        in_data  = word_at(3, 17);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_valid && in_ready) k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("fill_no_more_accepts", k, 0);
        check_eq("fill_done_held", done, 1);
        check_eq("fill_poly_stable", n_diff(poly, fillp), 0);

        // Backpressure: gapped run must match the gap-free run and the model.
        model(2, expp, ew);
        pulse_start();
        feed(2, 0, 4000, -1, w, c);
        check_eq("rnd_done", done, 1);
        check_eq("rnd_poly", n_diff(poly, expp), 0);
        check_eq("rnd_words", w, ew);
        gapfree = poly;
        pulse_start();
        feed(2, 5, 8000, -1, w, c);
        check_eq("gap_done", done, 1);
        check_eq("gap_poly_model", n_diff(poly, expp), 0);
        check_eq("gap_poly_vs_nogap", n_diff(poly, gapfree), 0);
        check_eq("gap_words", w, ew);

        // Reset mid-SCAN once ctr has reached 100.
        pulse_start();
        feed(0, 0, 57, -1, w, c);
        check_eq("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_poly_nonzero", n_diff(poly, '0), 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_busy", busy, 0);
        pulse_start();
        feed(0, 0, 2000, -1, w, c);
        check_eq("midrst_rerun_cycle", c, 145);
        check_eq("midrst_rerun_poly", n_diff(poly, golden), 0);

        // start while busy is ignored.
        pulse_start();
        feed(0, 0, 2000, 20, w, c);
        check_eq("busy_start_cycle", c, 145);
        check_eq("busy_start_words", w, 16);
        check_eq("busy_start_poly", n_diff(poly, golden), 0);

        // start together with rst: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_start_done", done, 0);
        check_eq("rst_start_busy", busy, 0);
        @(negedge clk);
        check_eq("rst_start_still_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rej_bounded_poly.md
Name: rej_bounded_poly

Overview:
- Rejection sampler for one ML-DSA/Dilithium secret polynomial: RejBoundedPoly over a SHAKE256 output stream.
- Consumes 64-bit squeeze words from the Keccak core over a valid/ready handshake.
- Emits 256 packed coefficients in [-ETA, ETA].
- Sits directly upstream of ExpandS polynomial assembly. ExpandS instantiates it once per s1/s2 polynomial, re-seeded per nonce.

Parameters:
- N, 256, coefficients per polynomial.
- ETA, 2, secret bound; only 2 and 4 are legal.
- COEFF_WIDTH, 4, bits per stored coefficient.
- DATA_IN_BITS, 64, squeeze word width; must be a multiple of 8.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins sampling; ignored unless in IDLE or DONE.
- in_data  in  DATA_IN_BITS  squeeze word; byte 0 = in_data[7:0] is first in stream order.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sampler will accept a word this cycle.
- poly  out  COEFF_WIDTH*N  coefficient i at poly[COEFF_WIDTH*i +: COEFF_WIDTH], 4-bit two's complement.
- busy  out  1  high in WAIT_WORD and SCAN.
- done  out  1  level; high in DONE until next start or rst.

Behaviour:
- Reset, on the clock edge with rst=1: state=IDLE, poly=0, coefficient counter ctr=0, byte index=0, in_ready=0, busy=0, done=0. Applies mid-operation too; any partial poly is discarded.
- IDLE/DONE + start: clear ctr and byte index, go to WAIT_WORD next cycle. poly is not cleared; every entry is overwritten before done.
- WAIT_WORD: in_ready=1. On in_valid&&in_ready, latch the word and go to SCAN. With in_valid=0, hold with no state change.
- SCAN: one byte per cycle, byte index 0..DATA_IN_BITS/8-1.
  - z0 = byte[3:0] is evaluated first, then z1 = byte[7:4].
  - Up to 2 coefficients are written per cycle.
  - in_ready=0 throughout SCAN.
- Acceptance test:
  - ETA=2: accept z<15; coeff = 2 - (z mod 5).
  - ETA=4: accept z<9; coeff = 4 - z.
  - Rejected nibbles write nothing and do not advance ctr.
- Write order: an accepted z0 writes poly[ctr]; an accepted z1 writes the next index.
- Fill boundary: if z0 fills entry N-1, z1 is discarded even if acceptable.
- When ctr reaches N, go to DONE next cycle. Remaining bytes of the latched word are discarded.
- End of word: after the last byte with ctr<N, return to WAIT_WORD.
- Throughput: 1 accept cycle + DATA_IN_BITS/8 scan cycles per fully consumed word.
- DONE: done=1, poly stable, in_ready=0. Sampler does not request further words; the ExpandS FSM owns Keccak squeeze/reset.
- start while busy: ignored.
- start in the same cycle as rst: rst wins.
- ctr is 9 bits, saturating at N; it never wraps.

Test Plan:
- All-zero stream, ETA=2, start at cycle T:
  - every coefficient = 4'h2;
  - exactly 16 words accepted;
  - done rises at T+145;
  - in_ready=0 from the cycle after the 16th accept.
- All-0xFF words, ETA=2, 40 words:
  - ctr stays 0 and done stays 0;
  - in_ready re-asserts every 9 cycles.
  - Then switch to zero words: completes after 16 more words.
- Word with byte0=0x3E, ETA=2:
  - poly[0]=4'hE (-2), poly[1]=4'hF (-1).
  - Byte 0xF7 yields a single coefficient 4'h0 (z0=7 → 7 mod 5=2 → 0); F rejected.
  - Repeat with ETA=4: byte 0x08 gives poly[0]=4'hC (-4), poly[1]=4'h4.
- Fill boundary:
  - feed 255 coefficients, then word byte0=0x00;
  - only poly[255]=4'h2 written;
  - done next cycle; rest of the word discarded; in_valid held high but no further accept.
- Backpressure: random in_valid gaps of 0-5 cycles → poly identical to the gap-free run; no word lost or duplicated.
- Reset mid-SCAN at ctr=100:
  - next cycle poly=0, ctr=0, done=0, in_ready=0;
  - a fresh start reproduces the golden all-zero result.
  - Also: start pulsed while busy → no restart, result unchanged.
